// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide issue stage: mdu op codes,
// RV32M funct3 codes, issue FSM states and the funct3 -> op mapping.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL  = 3'b000,
    MDU_MULH = 3'b001,
    MDU_DIV  = 3'b010,
    MDU_DIVU = 3'b011,
    MDU_REM  = 3'b100,
    MDU_REMU = 3'b101
  } mdu_op_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  function automatic logic f3_is_legal(input logic [2:0] f3);
    return !((f3 == F3_MULHSU) || (f3 == F3_MULHU));
  endfunction

  function automatic mdu_op_e f3_to_op(input logic [2:0] f3);
    mdu_op_e op;
    case (f3)
      F3_MUL:  op = MDU_MUL;
      F3_MULH: op = MDU_MULH;
      F3_DIV:  op = MDU_DIV;
      F3_DIVU: op = MDU_DIVU;
      F3_REM:  op = MDU_REM;
      F3_REMU: op = MDU_REMU;
      default: op = MDU_MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mdu_fixup.sv
// Corrects raw mdu divide/remainder results to RISC-V semantics for
// divide-by-zero and signed overflow. Purely combinational.
module mdu_fixup
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  mdu_op_e         i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_result,
  output logic [XLEN-1:0] o_result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic w_div0;
  logic w_ovf;

  assign w_div0 = (i_rs2 == '0);
  assign w_ovf  = (i_rs1 == MIN_NEG) && (i_rs2 == '1);

  // Override the raw result only for the architecturally defined corner cases.
  always_comb begin
    o_result = i_result;
    case (i_op)
      MDU_DIV: begin
        if (w_div0)     o_result = '1;
        else if (w_ovf) o_result = MIN_NEG;
      end
      MDU_DIVU: begin
        if (w_div0) o_result = '1;
      end
      MDU_REM: begin
        if (w_div0)     o_result = i_rs1;
        else if (w_ovf) o_result = '0;
      end
      MDU_REMU: begin
        if (w_div0) o_result = i_rs1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_issue.sv
// Execute-stage front end for the combinational mdu. Registers operands,
// holds them for LATENCY cycles (multicycle path), captures the result and
// hands it to writeback over valid/ready.
// Optional feature macro: RISCV_DIV_FIXUP_EN (RISC-V divide corner-case fixup).
module mdu_issue
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned LATENCY = 2   // legal 1..15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  output logic [XLEN-1:0] mdu_rs1,
  output logic [XLEN-1:0] mdu_rs2,
  output logic [2:0]      mdu_op,
  input  logic [XLEN-1:0] mdu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            out_illegal
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e          r_state;
  state_e          w_next;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  mdu_op_e         r_op;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_data;
  logic            r_illegal;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_legal;
  logic [XLEN-1:0] w_result;

  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_legal    = f3_is_legal(in_funct3);

`ifdef RISCV_DIV_FIXUP_EN
  mdu_fixup #(.XLEN(XLEN)) u_fixup (
    .i_op     (r_op),
    .i_rs1    (r_rs1),
    .i_rs2    (r_rs2),
    .i_result (mdu_result),
    .o_result (w_result)
  );
`else
  assign w_result = mdu_result;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; flush overrides everything, including a same-cycle accept.
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_next = w_legal ? S_BUSY : S_DONE;
        S_BUSY: if (r_cnt == '0) w_next = S_DONE;
        S_DONE: begin
          if (w_accept)       w_next = w_legal ? S_BUSY : S_DONE;
          else if (out_ready) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Operand/result registers: latch on accept, count down while busy, capture at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_op      <= MDU_MUL;
      r_rd      <= '0;
      r_data    <= '0;
      r_illegal <= 1'b0;
    end else if (!flush) begin
      if (w_accept) begin
        r_rd <= in_rd;
        if (w_legal) begin
          r_rs1 <= in_rs1;
          r_rs2 <= in_rs2;
          r_op  <= f3_to_op(in_funct3);
          r_cnt <= CNT_INIT;
        end else begin
          r_data    <= '0;
          r_illegal <= 1'b1;
        end
      end else if (r_state == S_BUSY) begin
        if (r_cnt == '0) begin
          r_data    <= w_result;
          r_illegal <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign mdu_rs1     = r_rs1;
  assign mdu_rs2     = r_rs2;
  assign mdu_op      = r_op;
  assign out_valid   = (r_state == S_DONE);
  assign out_rd      = r_rd;
  assign out_data    = r_data;
  assign out_illegal = r_illegal;

endmodule
